// File: rtl/gpio_ahb_pkg.sv
// Shared AHB-lite types and GPIO register map for the command master and its bench.
package gpio_ahb_pkg;

  localparam int unsigned AHB_ADDR_W = 32;
  localparam int unsigned AHB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef struct packed {
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic [AHB_DATA_W-1:0] wdata;
  } ahb_cmd_t;

  localparam logic [AHB_ADDR_W-1:0] GPIO_DATA_OFS = 32'h0000_0000;
  localparam logic [AHB_ADDR_W-1:0] GPIO_DIR_OFS  = 32'h0000_0004;
  localparam logic [AHB_ADDR_W-1:0] GPIO_SET_OFS  = 32'h0000_0008;
  localparam logic [AHB_ADDR_W-1:0] GPIO_CLR_OFS  = 32'h0000_000C;

endpackage

// File: rtl/ahb_wait_watchdog.sv
// Counts consecutive stalled data-phase edges and raises a sticky timeout flag
// once WAIT_LIMIT is reached; the stalled transfer itself is left alone.
module ahb_wait_watchdog #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam logic [7:0] LP_LIMIT    = 8'(WAIT_LIMIT);
  localparam logic [7:0] LP_LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  logic [7:0] r_cnt;
  logic       r_timeout;
  logic       w_stall;

  assign w_stall = active && !ready;
  assign timeout = r_timeout;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (w_stall) begin
      if (r_cnt != LP_LIMIT) r_cnt <= r_cnt + 8'd1;
      // r_cnt saturates at the limit, so >= covers the edge that reaches it and later ones
      if (r_cnt >= LP_LIMIT_M1) r_timeout <= 1'b1;
    end else if (ready) begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// Single-master AHB-lite initiator: valid/ready commands become pipelined
// single NONSEQ transfers with an address stage (A) and a data stage (D).
module ahb_lite_cmd_master
  import gpio_ahb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic              HSEL,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HREADY,
  input  logic              HREADYOUT,
  input  logic [DATA_W-1:0] HRDATA
);

  logic              r_a_valid;
  logic              r_a_write;
  logic [ADDR_W-1:0] r_a_addr;
  logic [DATA_W-1:0] r_a_wdata;
  logic              r_d_valid;
  logic              r_d_write;
  logic [DATA_W-1:0] r_hwdata;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic w_accept;
  logic w_complete;
  logic w_timeout;

  // A may be refilled while the slave stalls as long as it is empty
  assign cmd_ready  = !r_a_valid || HREADYOUT;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_complete = r_d_valid && HREADYOUT;

  assign HREADY      = HREADYOUT;
  assign HTRANS      = r_a_valid ? NONSEQ : IDLE;
  assign HSEL        = r_a_valid;
  assign HADDR       = r_a_addr;
  assign HWRITE      = r_a_write;
  assign HWDATA      = r_hwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_write   = r_rsp_write;
  assign rsp_rdata   = r_rsp_rdata;
  assign timeout_err = w_timeout;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_a_valid   <= 1'b0;
      r_a_write   <= 1'b0;
      r_a_addr    <= '0;
      r_a_wdata   <= '0;
      r_d_valid   <= 1'b0;
      r_d_write   <= 1'b0;
      r_hwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_complete;
      if (w_complete) begin
        r_rsp_write <= r_d_write;
        r_rsp_rdata <= r_d_write ? '0 : HRDATA;
      end

      if (HREADYOUT) begin
        r_d_valid <= r_a_valid;
        // HWDATA keeps its last value when the data stage drains
        if (r_a_valid) begin
          r_d_write <= r_a_write;
          r_hwdata  <= r_a_wdata;
        end
      end

      if (w_accept) begin
        r_a_valid <= 1'b1;
        r_a_write <= cmd_write;
        r_a_addr  <= cmd_addr;
        r_a_wdata <= cmd_wdata;
      end else if (HREADYOUT) begin
        r_a_valid <= 1'b0;
      end
    end
  end

  ahb_wait_watchdog #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wdog (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .active  (r_d_valid),
    .ready   (HREADYOUT),
    .timeout (w_timeout)
  );

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: directed scenarios plus a randomized run
// checked against a queue-based transaction model.
module tb_ahb_lite_cmd_master;
  import gpio_ahb_pkg::*;

  localparam int unsigned LIM = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        timeout_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  int checks = 0;
  int errors = 0;

  ahb_lite_cmd_master #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .WAIT_LIMIT (LIM)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .timeout_err (timeout_err),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSEL        (HSEL),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HREADYOUT   (HREADYOUT),
    .HRDATA      (HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic [31:0] rd);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    HREADYOUT = rdy;
    HRDATA    = rd;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    #12;
    checks++;
    if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HADDR !== 32'h0 || HWDATA !== 32'h0 || HWRITE !== 1'b0) begin
      errors++;
      $display("FAIL reset_ahb: HTRANS=%b HSEL=%b HADDR=%h HWDATA=%h HWRITE=%b, want all 0",
               HTRANS, HSEL, HADDR, HWDATA, HWRITE);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_rdata !== 32'h0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: rsp_valid=%b rsp_write=%b rsp_rdata=%h timeout_err=%b, want 0",
               rsp_valid, rsp_write, rsp_rdata, timeout_err);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_single_write();
    @(negedge HCLK);
    drive(1'b1, 1'b1, GPIO_DIR_OFS, 32'h0000_00A5, 1'b1, 32'h0);
    @(negedge HCLK);
    checks++;
    if (HTRANS !== 2'b10 || HSEL !== 1'b1 || HADDR !== 32'h4 || HWRITE !== 1'b1) begin
      errors++;
      $display("FAIL wr_addr_phase: HTRANS=%b HSEL=%b HADDR=%h HWRITE=%b want 10/1/4/1",
               HTRANS, HSEL, HADDR, HWRITE);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    @(negedge HCLK);
    checks++;
    if (HWDATA !== 32'h0000_00A5 || HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_data_phase: HWDATA=%h HTRANS=%b rsp_valid=%b want a5/00/0",
               HWDATA, HTRANS, rsp_valid);
    end
    @(negedge HCLK);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_rsp: rsp_valid=%b rsp_write=%b rsp_rdata=%h want 1/1/0",
               rsp_valid, rsp_write, rsp_rdata);
    end
    @(negedge HCLK);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp_pulse: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_single_read();
    @(negedge HCLK);
    drive(1'b1, 1'b0, GPIO_DATA_OFS, 32'h0, 1'b1, 32'h0000_1234);
    @(negedge HCLK);
    checks++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h0 || HWRITE !== 1'b0) begin
      errors++;
      $display("FAIL rd_addr_phase: HTRANS=%b HADDR=%h HWRITE=%b want 10/0/0", HTRANS, HADDR, HWRITE);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_1234);
    @(negedge HCLK);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_early_rsp: rsp_valid=%b want 0", rsp_valid);
    end
    @(negedge HCLK);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h0000_1234) begin
      errors++;
      $display("FAIL rd_rsp: rsp_valid=%b rsp_write=%b rsp_rdata=%h want 1/0/1234",
               rsp_valid, rsp_write, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr [3];
    logic [31:0] wd   [3];
    logic        wr   [3];
    addr[0] = GPIO_DATA_OFS; wd[0] = 32'h11; wr[0] = 1'b1;
    addr[1] = GPIO_DIR_OFS;  wd[1] = 32'h22; wr[1] = 1'b0;
    addr[2] = GPIO_SET_OFS;  wd[2] = 32'h33; wr[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      if (i >= 1 && i <= 3) begin
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== addr[i-1] || HWRITE !== wr[i-1]) begin
          errors++;
          $display("FAIL b2b_addr[%0d]: HTRANS=%b HADDR=%h HWRITE=%b want 10/%h/%b",
                   i, HTRANS, HADDR, HWRITE, addr[i-1], wr[i-1]);
        end
      end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (HWDATA !== wd[i-2]) begin
          errors++;
          $display("FAIL b2b_hwdata[%0d]: got %h want %h", i, HWDATA, wd[i-2]);
        end
      end
      if (i >= 3) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_write !== wr[i-3] ||
            rsp_rdata !== (wr[i-3] ? 32'h0 : 32'hCAFE_0004)) begin
          errors++;
          $display("FAIL b2b_rsp[%0d]: valid=%b write=%b rdata=%h want 1/%b", i,
                   rsp_valid, rsp_write, rsp_rdata, wr[i-3]);
        end
      end
      if (i < 3) drive(1'b1, wr[i], addr[i], wd[i], 1'b1, 32'hCAFE_0004);
      else       drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFE_0004);
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", i, cmd_ready);
      end
    end
    @(negedge HCLK);
    checks++;
    if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin
      errors++;
      $display("FAIL b2b_drain: rsp_valid=%b HTRANS=%b want 0/00", rsp_valid, HTRANS);
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      if (i >= 2 && i <= 5) begin
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== GPIO_CLR_OFS || HWRITE !== 1'b1) begin
          errors++;
          $display("FAIL ws_hold[%0d]: HTRANS=%b HADDR=%h HWRITE=%b want 10/c/1",
                   i, HTRANS, HADDR, HWRITE);
        end
      end
      if (i >= 3 && i <= 5) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL ws_early_rsp[%0d]: rsp_valid=%b want 0", i, rsp_valid);
        end
      end
      if (i == 6) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h55AA ||
            HWDATA !== 32'h77 || HTRANS !== 2'b00) begin
          errors++;
          $display("FAIL ws_read_rsp: valid=%b write=%b rdata=%h HWDATA=%h HTRANS=%b want 1/0/55aa/77/00",
                   rsp_valid, rsp_write, rsp_rdata, HWDATA, HTRANS);
        end
      end
      if (i == 7) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0 || timeout_err !== 1'b0) begin
          errors++;
          $display("FAIL ws_write_rsp: valid=%b write=%b rdata=%h timeout=%b want 1/1/0/0",
                   rsp_valid, rsp_write, rsp_rdata, timeout_err);
        end
      end
      case (i)
        0:       drive(1'b1, 1'b0, GPIO_SET_OFS, 32'h0, 1'b1, 32'h0);
        1:       drive(1'b1, 1'b1, GPIO_CLR_OFS, 32'h77, 1'b1, 32'h0);
        2, 3, 4: drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEAD);
        default: drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h55AA);
      endcase
      #1;
      if (i >= 2 && i <= 4) begin
        checks++;
        if (cmd_ready !== 1'b0 || HREADY !== 1'b0) begin
          errors++;
          $display("FAIL ws_ready[%0d]: cmd_ready=%b HREADY=%b want 0/0", i, cmd_ready, HREADY);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 9; i++) begin
      @(negedge HCLK);
      if (i == 5) begin
        checks++;
        if (timeout_err !== 1'b0) begin
          errors++;
          $display("FAIL wd_early: timeout_err=%b want 0 after 3 wait edges", timeout_err);
        end
      end
      if (i == 6) begin
        checks++;
        if (timeout_err !== 1'b1 || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL wd_set: timeout_err=%b rsp_valid=%b want 1/0", timeout_err, rsp_valid);
        end
      end
      if (i == 7) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBEEF || timeout_err !== 1'b1) begin
          errors++;
          $display("FAIL wd_rsp: rsp_valid=%b rdata=%h timeout_err=%b want 1/beef/1",
                   rsp_valid, rsp_rdata, timeout_err);
        end
      end
      if (i == 8) begin
        checks++;
        if (timeout_err !== 1'b1) begin
          errors++;
          $display("FAIL wd_sticky: timeout_err=%b want 1", timeout_err);
        end
      end
      if (i == 0)                drive(1'b1, 1'b0, GPIO_DATA_OFS, 32'h0, 1'b1, 32'h0);
      else if (i >= 2 && i <= 5) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      else                       drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBEEF);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge HCLK);
    drive(1'b1, 1'b1, GPIO_SET_OFS, 32'h0F0F, 1'b1, 32'h0);
    @(negedge HCLK);
    drive(1'b1, 1'b1, GPIO_CLR_OFS, 32'hF0F0, 1'b1, 32'h0);
    @(negedge HCLK);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge HCLK);
    checks++;
    if (HTRANS !== 2'b10 || HWDATA !== 32'h0F0F) begin
      errors++;
      $display("FAIL rmw_pre: HTRANS=%b HWDATA=%h want 10/0f0f", HTRANS, HWDATA);
    end
    HRESETn = 1'b0;
    #1;
    checks++;
    if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HWDATA !== 32'h0 || rsp_valid !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rmw_reset: HTRANS=%b HSEL=%b HWDATA=%h rsp_valid=%b timeout=%b want 00/0/0/0/0",
               HTRANS, HSEL, HWDATA, rsp_valid, timeout_err);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin
        errors++;
        $display("FAIL rmw_after[%0d]: cmd_ready=%b rsp_valid=%b HTRANS=%b want 1/0/00",
                 i, cmd_ready, rsp_valid, HTRANS);
      end
    end
  endtask

  task automatic test_random();
    ahb_cmd_t    aq[$];
    ahb_cmd_t    dq[$];
    ahb_cmd_t    c;
    logic [31:0] m_hwdata = 32'h0;
    logic        m_rsp_v = 1'b0;
    logic        m_rsp_w = 1'b0;
    logic [31:0] m_rsp_d = 32'h0;
    logic        m_to = 1'b0;
    int          m_waits = 0;
    logic        v, w, rdy, acc;
    logic [31:0] a, d, rd;

    @(negedge HCLK);
    HRESETn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge HCLK);
      checks++;
      if (HTRANS !== (aq.size() != 0 ? 2'b10 : 2'b00) || HSEL !== (aq.size() != 0)) begin
        errors++;
        $display("FAIL rnd_htrans[%0d]: HTRANS=%b HSEL=%b pending_addr=%0d", cyc, HTRANS, HSEL, aq.size());
      end
      if (aq.size() != 0) begin
        checks++;
        if (HADDR !== aq[0].addr || HWRITE !== aq[0].write) begin
          errors++;
          $display("FAIL rnd_addr[%0d]: HADDR=%h HWRITE=%b want %h/%b",
                   cyc, HADDR, HWRITE, aq[0].addr, aq[0].write);
        end
      end
      checks++;
      if (HWDATA !== m_hwdata) begin
        errors++;
        $display("FAIL rnd_hwdata[%0d]: got %h want %h", cyc, HWDATA, m_hwdata);
      end
      checks++;
      if (rsp_valid !== m_rsp_v || (m_rsp_v && (rsp_write !== m_rsp_w || rsp_rdata !== m_rsp_d))) begin
        errors++;
        $display("FAIL rnd_rsp[%0d]: valid=%b write=%b rdata=%h want %b/%b/%h",
                 cyc, rsp_valid, rsp_write, rsp_rdata, m_rsp_v, m_rsp_w, m_rsp_d);
      end
      checks++;
      if (timeout_err !== m_to) begin
        errors++;
        $display("FAIL rnd_timeout[%0d]: got %b want %b", cyc, timeout_err, m_to);
      end

      v   = ($urandom_range(0, 3) != 0);
      w   = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 3)) << 2;
      d   = $urandom;
      rdy = ($urandom_range(0, 4) != 0);
      rd  = $urandom;
      drive(v, w, a, d, rdy, rd);
      #1;
      checks++;
      if (cmd_ready !== (aq.size() == 0 || rdy) || HREADY !== rdy) begin
        errors++;
        $display("FAIL rnd_ready[%0d]: cmd_ready=%b HREADY=%b want %b/%b",
                 cyc, cmd_ready, HREADY, (aq.size() == 0 || rdy), rdy);
      end

      acc = v && (aq.size() == 0 || rdy);
      if (dq.size() != 0 && !rdy) begin
        if (m_waits < int'(LIM)) m_waits++;
        if (m_waits >= int'(LIM)) m_to = 1'b1;
      end else if (rdy) begin
        m_waits = 0;
      end
      m_rsp_v = 1'b0;
      if (rdy) begin
        if (dq.size() != 0) begin
          c = dq.pop_front();
          m_rsp_v = 1'b1;
          m_rsp_w = c.write;
          m_rsp_d = c.write ? 32'h0 : rd;
        end
        if (aq.size() != 0) begin
          c = aq.pop_front();
          m_hwdata = c.wdata;
          dq.push_back(c);
        end
      end
      if (acc) begin
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        aq.push_back(c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_watchdog();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
